// File: rtl/reg_writeback.sv
// Register-file write master: merges vector ALU results and multi-beat memory
// loads into a single registered write port, loads taking priority over ALU.
module reg_writeback #(
  parameter int registerSize  = 8,
  parameter int vectorSize    = 4,
  parameter int selectionBits = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 aluValid,
  output logic                                 aluReady,
  input  logic [selectionBits:0]               aluDest,
  input  logic [vectorSize*registerSize-1:0]   aluData,
  input  logic                                 memValid,
  output logic                                 memReady,
  input  logic [selectionBits:0]               memDest,
  input  logic [registerSize-1:0]              memData,
  output logic                                 regWrEnSc,
  output logic                                 regWrEnVec,
  output logic [selectionBits:0]               regToWrite,
  output logic [vectorSize*registerSize-1:0]   dataIn,
  output logic                                 busy
);

  localparam int DATA_W = vectorSize * registerSize;
  localparam int CNT_W  = (vectorSize > 1) ? $clog2(vectorSize) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(vectorSize - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        lane_cnt;
  logic [registerSize-1:0] lanes [vectorSize];
  logic [selectionBits:0]  load_dest;
  logic [DATA_W-1:0]       load_data;

  logic                    alu_full;
  logic [selectionBits:0]  alu_dest_q;
  logic [DATA_W-1:0]       alu_data_q;

  logic                    mem_accept, alu_accept, alu_drain;
  logic                    sel_valid;
  logic [selectionBits:0]  sel_dest;
  logic [DATA_W-1:0]       sel_data;

  assign mem_accept = memValid && memReady;
  assign alu_accept = aluValid && aluReady;
  assign alu_drain  = alu_full && (state != COMMIT);
  assign aluReady   = !alu_full || (state != COMMIT);
  assign busy       = (state != IDLE) || alu_full;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_accept) state_next = memDest[selectionBits] ? COMMIT : COLLECT;
      end
      COLLECT: begin
        if (mem_accept && lane_cnt == LAST_LANE) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    memReady  = 1'b1;
    sel_valid = 1'b0;
    sel_dest  = '0;
    sel_data  = '0;
    if (state == COMMIT) begin
      memReady  = 1'b0;
      sel_valid = 1'b1;
      sel_dest  = load_dest;
      sel_data  = load_data;
    end else if (alu_full) begin
      sel_valid = 1'b1;
      sel_dest  = alu_dest_q;
      sel_data  = alu_data_q;
    end
  end

  always_comb begin
    load_data = '0;
    for (int i = 0; i < vectorSize; i++)
      load_data[i*registerSize +: registerSize] = lanes[i];
  end

  // NOTE: lane storage is small flop storage, so it takes the async reset
  // like any other state; a partial vector never survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_cnt  <= '0;
      load_dest <= '0;
      lanes     <= '{default: '0};
    end else if (mem_accept) begin
      if (state == IDLE) begin
        // Clearing the upper lanes gives scalar loads their zero padding.
        load_dest <= memDest;
        lanes     <= '{default: '0};
        lanes[0]  <= memData;
        lane_cnt  <= CNT_W'(1);
      end else begin
        lanes[lane_cnt] <= memData;
        lane_cnt        <= lane_cnt + 1'b1;
      end
    end
  end

  // A result accepted in the draining cycle refills the buffer directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_full   <= 1'b0;
      alu_dest_q <= '0;
      alu_data_q <= '0;
    end else if (alu_accept) begin
      alu_full   <= 1'b1;
      alu_dest_q <= aluDest;
      alu_data_q <= aluData;
    end else if (alu_drain) begin
      alu_full   <= 1'b0;
    end
  end

  // Destination and data hold their last value when no write is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrEnSc  <= 1'b0;
      regWrEnVec <= 1'b0;
      regToWrite <= '0;
      dataIn     <= '0;
    end else begin
      regWrEnSc  <= sel_valid &&  sel_dest[selectionBits];
      regWrEnVec <= sel_valid && !sel_dest[selectionBits];
      if (sel_valid) begin
        regToWrite <= sel_dest;
        dataIn     <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback: ALU writes, vector/scalar
// loads, load-before-ALU ordering, ALU streaming and reset mid-load.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid, aluReady;
  logic [3:0]  aluDest;
  logic [31:0] aluData;
  logic        memValid, memReady;
  logic [3:0]  memDest;
  logic [7:0]  memData;
  logic        regWrEnSc, regWrEnVec;
  logic [3:0]  regToWrite;
  logic [31:0] dataIn;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  reg_writeback #(.registerSize(8), .vectorSize(4), .selectionBits(3)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReady(aluReady), .aluDest(aluDest), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memDest(memDest), .memData(memData),
    .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .regToWrite(regToWrite),
    .dataIn(dataIn), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; aluValid = 1'b0; aluDest = '0; aluData = '0;
    memValid = 1'b0; memDest = '0; memData = '0;
    tick; tick;
    vectors++; if (regWrEnSc !== 1'b0) begin errors++; $display("FAIL reset_en_sc: got %b want 0", regWrEnSc); end
    vectors++; if (regWrEnVec !== 1'b0) begin errors++; $display("FAIL reset_en_vec: got %b want 0", regWrEnVec); end
    vectors++; if (regToWrite !== 4'h0) begin errors++; $display("FAIL reset_dest: got %h want 0", regToWrite); end
    vectors++; if (dataIn !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dataIn); end
    vectors++; if (memReady !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b want 1", memReady); end
    vectors++; if (aluReady !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b want 1", aluReady); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    tick;
    vectors++; if (busy !== 1'b0 || regWrEnVec !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy %b en_vec %b want 0 0", busy, regWrEnVec); end
  endtask

  task automatic test_alu_single;
    aluValid = 1'b1; aluDest = 4'b0010; aluData = 32'h44332211;
    vectors++; if (aluReady !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", aluReady); end
    tick;
    aluValid = 1'b0; aluData = '0; aluDest = '0;
    vectors++; if (regWrEnVec !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL alu_latency: en_vec %b busy %b want 0 1", regWrEnVec, busy); end
    tick;
    vectors++; if (regWrEnVec !== 1'b1 || regWrEnSc !== 1'b0) begin errors++; $display("FAIL alu_enables: vec %b sc %b want 1 0", regWrEnVec, regWrEnSc); end
    vectors++; if (regToWrite !== 4'h2) begin errors++; $display("FAIL alu_dest: got %h want 2", regToWrite); end
    vectors++; if (dataIn !== 32'h44332211) begin errors++; $display("FAIL alu_data: got %h want 44332211", dataIn); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL alu_busy_clear: got %b want 0", busy); end
    tick;
    vectors++; if (regWrEnVec !== 1'b0 || regToWrite !== 4'h2) begin errors++; $display("FAIL alu_pulse_hold: en_vec %b dest %h want 0 2", regWrEnVec, regToWrite); end
  endtask

  task automatic test_vector_load;
    memValid = 1'b1; memDest = 4'b0001; memData = 8'hA0;
    tick;
    memDest = 4'b1111; memData = 8'hA1;
    tick;
    memValid = 1'b0; memData = 8'hFF;
    tick;
    vectors++; if (busy !== 1'b1 || regWrEnVec !== 1'b0 || memReady !== 1'b1) begin errors++; $display("FAIL vload_gap: busy %b en_vec %b mem_ready %b want 1 0 1", busy, regWrEnVec, memReady); end
    memValid = 1'b1; memData = 8'hA2;
    tick;
    memData = 8'hA3;
    vectors++; if (memReady !== 1'b1) begin errors++; $display("FAIL vload_ready_last: got %b want 1", memReady); end
    tick;
    memValid = 1'b0; memData = '0; memDest = '0;
    vectors++; if (memReady !== 1'b0 || regWrEnVec !== 1'b0) begin errors++; $display("FAIL vload_commit: mem_ready %b en_vec %b want 0 0", memReady, regWrEnVec); end
    tick;
    vectors++; if (memReady !== 1'b1) begin errors++; $display("FAIL vload_ready_back: got %b want 1", memReady); end
    vectors++; if (regWrEnVec !== 1'b1 || regWrEnSc !== 1'b0) begin errors++; $display("FAIL vload_enables: vec %b sc %b want 1 0", regWrEnVec, regWrEnSc); end
    vectors++; if (regToWrite !== 4'h1) begin errors++; $display("FAIL vload_dest: got %h want 1", regToWrite); end
    vectors++; if (dataIn !== 32'hA3A2A1A0) begin errors++; $display("FAIL vload_data: got %h want a3a2a1a0", dataIn); end
    tick;
    vectors++; if (regWrEnVec !== 1'b0) begin errors++; $display("FAIL vload_single_write: got %b want 0", regWrEnVec); end
  endtask

  task automatic test_scalar_load;
    memValid = 1'b1; memDest = 4'b1011; memData = 8'h5C;
    tick;
    memValid = 1'b0; memData = '0; memDest = '0;
    vectors++; if (memReady !== 1'b0 || regWrEnSc !== 1'b0) begin errors++; $display("FAIL sload_commit: mem_ready %b en_sc %b want 0 0", memReady, regWrEnSc); end
    tick;
    vectors++; if (regWrEnSc !== 1'b1 || regWrEnVec !== 1'b0) begin errors++; $display("FAIL sload_enables: sc %b vec %b want 1 0", regWrEnSc, regWrEnVec); end
    vectors++; if (regToWrite !== 4'hB) begin errors++; $display("FAIL sload_dest: got %h want b", regToWrite); end
    vectors++; if (dataIn !== 32'h0000005C) begin errors++; $display("FAIL sload_data: got %h want 0000005c", dataIn); end
    tick;
    vectors++; if (regWrEnSc !== 1'b0) begin errors++; $display("FAIL sload_pulse: got %b want 0", regWrEnSc); end
  endtask

  task automatic test_ordering;
    memValid = 1'b1; memDest = 4'b0011; memData = 8'hB0;
    tick;
    memDest = 4'b0000; memData = 8'hB1;
    tick;
    memData = 8'hB2;
    tick;
    memData = 8'hB3;
    aluValid = 1'b1; aluDest = 4'b0011; aluData = 32'hDEADBEEF;
    vectors++; if (aluReady !== 1'b1) begin errors++; $display("FAIL order_ready_before: got %b want 1", aluReady); end
    tick;
    memValid = 1'b0; aluValid = 1'b0; aluData = '0; aluDest = '0;
    vectors++; if (aluReady !== 1'b0 || regWrEnVec !== 1'b0) begin errors++; $display("FAIL order_commit: alu_ready %b en_vec %b want 0 0", aluReady, regWrEnVec); end
    tick;
    vectors++; if (aluReady !== 1'b1) begin errors++; $display("FAIL order_ready_after: got %b want 1", aluReady); end
    vectors++; if (regWrEnVec !== 1'b1 || regToWrite !== 4'h3 || dataIn !== 32'hB3B2B1B0) begin errors++; $display("FAIL order_load_first: en %b dest %h data %h want 1 3 b3b2b1b0", regWrEnVec, regToWrite, dataIn); end
    tick;
    vectors++; if (regWrEnVec !== 1'b1 || regToWrite !== 4'h3 || dataIn !== 32'hDEADBEEF) begin errors++; $display("FAIL order_alu_second: en %b dest %h data %h want 1 3 deadbeef", regWrEnVec, regToWrite, dataIn); end
    tick;
    vectors++; if (regWrEnVec !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL order_done: en %b busy %b want 0 0", regWrEnVec, busy); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  exp_dest;
    logic [31:0] exp_data;
    for (int j = 0; j < 8; j++) begin
      aluValid = 1'b1; aluDest = 4'(2*j + 1); aluData = 32'h01010101 * (j + 1);
      vectors++; if (aluReady !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d: got %b want 1", j, aluReady); end
      tick;
      if (j > 0) begin
        exp_dest = 4'(2*(j-1) + 1); exp_data = 32'h01010101 * j;
        vectors++;
        if (regWrEnSc !== exp_dest[3] || regWrEnVec !== !exp_dest[3] || regToWrite !== exp_dest || dataIn !== exp_data) begin
          errors++;
          $display("FAIL stream_write_%0d: sc %b vec %b dest %h data %h want %b %b %h %h", j-1, regWrEnSc, regWrEnVec, regToWrite, dataIn, exp_dest[3], !exp_dest[3], exp_dest, exp_data);
        end
      end
    end
    aluValid = 1'b0; aluDest = '0; aluData = '0;
    tick;
    vectors++; if (regWrEnSc !== 1'b1 || regWrEnVec !== 1'b0 || regToWrite !== 4'hF || dataIn !== 32'h08080808) begin errors++; $display("FAIL stream_write_7: sc %b vec %b dest %h data %h want 1 0 f 08080808", regWrEnSc, regWrEnVec, regToWrite, dataIn); end
    tick;
    vectors++; if (regWrEnSc !== 1'b0 || regWrEnVec !== 1'b0) begin errors++; $display("FAIL stream_end: sc %b vec %b want 0 0", regWrEnSc, regWrEnVec); end
  endtask

  task automatic test_reset_mid_load;
    memValid = 1'b1; memDest = 4'b0000; memData = 8'hC0;
    tick;
    memData = 8'hC1;
    aluValid = 1'b1; aluDest = 4'b0101; aluData = 32'h12345678;
    tick;
    memValid = 1'b0; aluValid = 1'b0; aluData = '0; aluDest = '0;
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (regToWrite !== 4'h0 || dataIn !== 32'h0) begin errors++; $display("FAIL midrst_port_clear: dest %h data %h want 0 0", regToWrite, dataIn); end
    vectors++; if (busy !== 1'b0 || memReady !== 1'b1 || aluReady !== 1'b1) begin errors++; $display("FAIL midrst_ctrl: busy %b mem_ready %b alu_ready %b want 0 1 1", busy, memReady, aluReady); end
    tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++; if (regWrEnSc !== 1'b0 || regWrEnVec !== 1'b0) begin errors++; $display("FAIL midrst_no_write_%0d: sc %b vec %b want 0 0", k, regWrEnSc, regWrEnVec); end
    end
    for (int k = 0; k < 4; k++) begin
      memValid = 1'b1; memDest = 4'b0000; memData = 8'hD0 + 8'(k);
      tick;
    end
    memValid = 1'b0; memData = '0;
    tick;
    vectors++; if (regWrEnVec !== 1'b1 || regToWrite !== 4'h0 || dataIn !== 32'hD3D2D1D0) begin errors++; $display("FAIL midrst_fresh_load: en %b dest %h data %h want 1 0 d3d2d1d0", regWrEnVec, regToWrite, dataIn); end
  endtask

  initial begin
    test_reset;
    test_alu_single;
    test_vector_load;
    test_scalar_load;
    test_ordering;
    test_back_to_back;
    test_reset_mid_load;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side master for the register file: it merges results from the vector ALU (a whole vector per transfer) and from the memory load path (one element per beat), and issues at most one register-file write per cycle on the write port (regWrEnSc / regWrEnVec / regToWrite / dataIn). It sits between the execute/memory stages and the register file. It assembles multi-beat vector loads, arbitrates between the two sources and keeps write ordering deterministic.

## Interface
- registerSize, 8, bits per element
- vectorSize, 4, elements per vector
- selectionBits, 3, destination selector MSB index; regToWrite[selectionBits]=1 selects scalar bank, 0 selects vector bank
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- aluValid  in  1  ALU result offered
- aluReady  out  1  ALU result accepted when aluValid && aluReady at a rising edge
- aluDest  in  selectionBits+1  ALU destination register
- aluData  in  vectorSize x registerSize  ALU result; lane 0 only is meaningful for scalar destinations
- memValid  in  1  load beat offered
- memReady  out  1  beat accepted when memValid && memReady at a rising edge
- memDest  in  selectionBits+1  load destination, sampled on the first beat of a load only
- memData  in  registerSize  one element; lanes arrive in order 0..vectorSize-1
- regWrEnSc  out  1  scalar bank write enable (registered)
- regWrEnVec  out  1  vector bank write enable (registered)
- regToWrite  out  selectionBits+1  write destination (registered)
- dataIn  out  vectorSize x registerSize  write data (registered)
- busy  out  1  high while a load is partially collected, a commit is pending, or the ALU buffer is full

## Operation
- Load assembler FSM, states IDLE, COLLECT, COMMIT:
  - IDLE. On an accepted beat, latch memDest, store lane 0 and set laneCnt=1. Go to COMMIT if memDest MSB=1 (scalar load, single beat). Otherwise go to COLLECT.
  - COLLECT. Each accepted beat stores lane[laneCnt] and increments laneCnt. When the beat for lane vectorSize-1 is accepted, go to COMMIT. Cycles without memValid hold state; there is no timeout.
  - COMMIT. Lasts exactly one cycle, then returns to IDLE. memReady=0 in COMMIT and 1 in IDLE/COLLECT.
- Scalar load write data: lane 0 = memData, lanes 1..vectorSize-1 = 0.
- ALU path: one-entry buffer (aluFull, aluDest, aluData).
  - aluReady = !aluFull || (aluFull && state!=COMMIT), i.e. the buffer accepts a new result in the cycle it drains.
- Write selection, combinational from internal state and registered onto the write port at the next edge:
  - state==COMMIT: write the assembled load. It always wins.
  - else if aluFull: write the ALU buffer and clear it (or refill it if a new result is accepted in the same edge).
  - else: write enables go to 0. regToWrite and dataIn hold their last values.
- Enables are set by the destination MSB: MSB=1 gives regWrEnSc=1, regWrEnVec=0; MSB=0 gives the opposite. The two enables are never both 1.
- Ordering: same-destination conflict with COMMIT active and an ALU result buffered → the load is written first and the ALU result one cycle later, so the ALU value is final.

## Timing
- Reset (async):
  - State IDLE, laneCnt=0, aluFull=0, lanes=0.
  - regWrEnSc=regWrEnVec=0, regToWrite=0, dataIn=0.
  - memReady=1, aluReady=1, busy=0.
- ALU latency: accepted at edge E; write port driven after edge E+1 (absent a COMMIT); register file captures at edge E+2. A COMMIT delays the ALU write by exactly 1 cycle.
- Load latency: last (or only) beat accepted at edge E → COMMIT during E..E+1 → write port driven after edge E+1.
- Back-to-back loads: the next load's first beat is accepted no earlier than edge E+2, because memReady=0 during COMMIT.
- Sustained ALU throughput: 1 result/cycle with no loads.
- Enables are single-cycle pulses per write; consecutive writes produce consecutive high cycles.
- Reset mid-COLLECT discards the partial vector and issues no write. Reset with an ALU result buffered drops it.

## Test plan
- Reset released, then ALU result aluDest=4'b0010, aluData={8'h44,8'h33,8'h22,8'h11} → two edges later regWrEnVec=1 for one cycle, regToWrite=2, dataIn matches, regWrEnSc=0.
- Vector load memDest=4'b0001 with beats 8'hA0..8'hA3, including one idle cycle mid-stream → one write with regWrEnVec=1, regToWrite=1, dataIn={A3,A2,A1,A0}, memReady=0 for exactly one cycle.
- Scalar load memDest=4'b1011, memData=8'h5C → regWrEnSc=1, regToWrite=4'b1011, dataIn={0,0,0,8'h5C}, write issued one cycle after the beat.
- ALU buffered to dest 3 while the last beat of a load to dest 3 commits → load write in cycle N, ALU write in cycle N+1, aluReady low exactly one cycle.
- ALU stream of 8 consecutive results, no loads → 8 consecutive write cycles, aluReady constantly 1, destinations in order.
- reset asserted after 2 of 4 load beats → outputs immediately zero, no write afterward, and a fresh 4-beat load then completes correctly.
